// File: rtl/calc_param.sv
// calc_param: keypad calculator with NDIG-digit decimal operands, iterative
// multiply/divide, and a one-digit-per-cycle BCD scan toward the display mux.
module calc_param #(
  parameter int NDIG = 8,
  parameter int W    = 27,
  parameter int PW   = $clog2(NDIG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [3:0]    cmd,
  output logic          cmd_ready,
  output logic [1:0]    status,
  output logic [3:0]    data,
  output logic [PW-1:0] pos,
  output logic          digit_valid,
  output logic          neg
);

  // state   | meaning
  // ENTER_A | typing the first operand (or holding a chained result)
  // ENTER_B | typing the second operand after an operator
  // CALC    | add/sub in one cycle, mul/div iterate W cycles
  // SCAN    | emitting NDIG BCD digits, then back to r_ret
  // ERR     | only backspace/clear is acted on
  typedef enum logic [2:0] {S_ENTER_A, S_ENTER_B, S_CALC, S_SCAN, S_ERR} state_t;

  localparam int CW = $clog2(((W > NDIG) ? W : NDIG) + 1);
  localparam int TW = $clog2(NDIG + 1);
  localparam logic [2*W-1:0] MAXV = (2*W)'(64'd10 ** NDIG - 64'd1);
  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] K_EQ   = 4'hE;
  localparam logic [3:0] K_BS   = 4'hF;

  state_t r_state, w_state_next, r_ret;

  logic [W-1:0]   r_cur, r_a, r_b, r_scan, r_wb;
  logic [2*W-1:0] r_acc, r_wa;
  logic [3:0]     r_op;
  logic [TW-1:0]  r_ndig;
  logic [CW-1:0]  r_cnt;

  logic           w_accept, w_is_digit, w_is_op, w_last, w_div0, w_calc_end;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_diff;
  logic [2*W-1:0] w_acc_step, w_result;
  logic [W:0]     w_shift;
  logic           w_qbit;
  logic [W-1:0]   w_rem_next, w_q_next;
  logic [W-1:0]   w_src, w_quot;
  logic [3:0]     w_digit;
  logic           w_blank;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_is_digit = (cmd <= 4'd9);
  assign w_is_op    = (cmd >= OP_ADD) && (cmd <= OP_DIV);
  assign w_last     = (r_cnt == CW'(W - 1));
  assign w_div0     = (r_op == OP_DIV) && (r_b == '0);
  assign w_calc_end = (r_op == OP_ADD) || (r_op == OP_SUB) || w_last;

  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = (r_a >= r_b) ? (r_a - r_b) : (r_b - r_a);
  assign w_acc_step = r_wb[0] ? (r_acc + r_wa) : r_acc;

  // Restoring division: remainder lives in r_acc[W-1:0], quotient shifts into r_wa[W-1:0].
  assign w_shift    = {r_acc[W-1:0], r_wa[W-1]};
  assign w_qbit     = (w_shift >= {1'b0, r_b});
  assign w_rem_next = w_qbit ? W'(w_shift - {1'b0, r_b}) : w_shift[W-1:0];
  assign w_q_next   = {r_wa[W-2:0], w_qbit};

  always_comb begin
    w_result = {{(W-1){1'b0}}, w_sum};
    case (r_op)
      OP_SUB:  w_result = {{W{1'b0}}, w_diff};
      OP_MUL:  w_result = w_acc_step;
      OP_DIV:  w_result = {{W{1'b0}}, w_q_next};
      default: ;
    endcase
  end

  assign w_src   = (r_cnt == '0) ? r_cur : r_scan;
  assign w_quot  = w_src / W'(10);
  assign w_digit = 4'(w_src % W'(10));
  assign w_blank = (r_cnt != '0) && (w_src == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_ENTER_A;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    status       = 2'b01;
    case (r_state)
      S_ENTER_A: begin
        cmd_ready = 1'b1;
        status    = 2'b10;
        if (cmd_valid) w_state_next = w_is_op ? S_ENTER_B : S_SCAN;
      end
      S_ENTER_B: begin
        cmd_ready = 1'b1;
        status    = 2'b10;
        if (cmd_valid) begin
          if (w_is_op)          w_state_next = (r_ndig == '0) ? S_ENTER_B : S_ERR;
          else if (cmd == K_EQ) w_state_next = S_CALC;
          else                  w_state_next = S_SCAN;
        end
      end
      S_CALC: begin
        if (w_div0)          w_state_next = S_ERR;
        else if (w_calc_end) w_state_next = (w_result > MAXV) ? S_ERR : S_SCAN;
      end
      S_SCAN: begin
        if (r_cnt == CW'(NDIG)) w_state_next = r_ret;
      end
      S_ERR: begin
        cmd_ready = 1'b1;
        status    = 2'b00;
        if (cmd_valid && (cmd == K_BS)) w_state_next = S_SCAN;
      end
      default: w_state_next = S_ENTER_A;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cur       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_scan      <= '0;
      r_wb        <= '0;
      r_acc       <= '0;
      r_wa        <= '0;
      r_op        <= OP_ADD;
      r_ndig      <= '0;
      r_cnt       <= '0;
      r_ret       <= S_ENTER_A;
      data        <= 4'h0;
      pos         <= '0;
      digit_valid <= 1'b0;
      neg         <= 1'b0;
    end else begin
      case (r_state)
        S_ENTER_A, S_ENTER_B: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_is_digit) begin
              if (r_ndig < TW'(NDIG)) begin
                r_cur  <= r_cur * W'(10) + W'(cmd);
                r_ndig <= r_ndig + 1'b1;
              end
              neg   <= 1'b0;
              r_ret <= r_state;
            end else if (cmd == K_BS) begin
              r_cur <= r_cur / W'(10);
              if (r_ndig != '0) r_ndig <= r_ndig - 1'b1;
              neg   <= 1'b0;
              r_ret <= r_state;
            end else if (w_is_op) begin
              if (r_state == S_ENTER_A) begin
                r_a    <= r_cur;
                r_op   <= cmd;
                r_cur  <= '0;
                r_ndig <= '0;
                neg    <= 1'b0;
              end else if (r_ndig == '0) begin
                r_op <= cmd;
              end
            end else begin
              r_ret <= S_ENTER_A;
              if (r_state == S_ENTER_B) begin
                r_b   <= r_cur;
                r_acc <= '0;
                r_wa  <= {{W{1'b0}}, r_a};
                r_wb  <= r_cur;
              end
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == OP_MUL) begin
            r_acc <= w_acc_step;
            r_wa  <= r_wa << 1;
            r_wb  <= r_wb >> 1;
          end else if (r_op == OP_DIV) begin
            r_acc <= {{W{1'b0}}, w_rem_next};
            r_wa  <= {{W{1'b0}}, w_q_next};
          end
          if (w_state_next == S_SCAN) begin
            r_cur  <= w_result[W-1:0];
            r_ndig <= TW'(NDIG);
            neg    <= (r_op == OP_SUB) && (r_a < r_b);
            r_cnt  <= '0;
            r_ret  <= S_ENTER_A;
          end
        end
        S_SCAN: begin
          if (r_cnt == CW'(NDIG)) begin
            digit_valid <= 1'b0;
            r_cnt       <= '0;
          end else begin
            digit_valid <= 1'b1;
            pos         <= r_cnt[PW-1:0];
            data        <= w_blank ? 4'hF : w_digit;
            r_scan      <= w_quot;
            r_cnt       <= r_cnt + 1'b1;
          end
        end
        S_ERR: begin
          if (w_accept && (cmd == K_BS)) begin
            r_cur       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_scan      <= '0;
            r_wb        <= '0;
            r_acc       <= '0;
            r_wa        <= '0;
            r_op        <= OP_ADD;
            r_ndig      <= '0;
            r_cnt       <= '0;
            r_ret       <= S_ENTER_A;
            data        <= 4'h0;
            pos         <= '0;
            digit_valid <= 1'b0;
            neg         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
